// File: rtl/bingo_pkg.sv
// Shared encodings for the master-board Bingo turn sequencer:
// link message types, winner codes and FSM state numbering.
package bingo_pkg;

  localparam logic [2:0] MSG_START    = 3'd0;
  localparam logic [2:0] MSG_SEL_DONE = 3'd1;
  localparam logic [2:0] MSG_GUESS    = 3'd2;
  localparam logic [2:0] MSG_REPORT   = 3'd3;
  localparam logic [2:0] MSG_RESULT   = 3'd4;
  localparam logic [2:0] MSG_RESTART  = 3'd5;

  localparam logic [1:0] WIN_NONE   = 2'd0;
  localparam logic [1:0] WIN_MASTER = 2'd1;
  localparam logic [1:0] WIN_SLAVE  = 2'd2;
  localparam logic [1:0] WIN_TIE    = 2'd3;

  localparam logic [4:0] MAX_NUM = 5'd24;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SEND_START = 4'd1,
    S_SELECT     = 4'd2,
    S_MY_TURN    = 4'd3,
    S_MY_WAIT    = 4'd4,
    S_MY_TX      = 4'd5,
    S_WAIT_REP   = 4'd6,
    S_DECIDE     = 4'd7,
    S_PEER_TURN  = 4'd8,
    S_GAME_OVER  = 4'd9
  } state_e;

  function automatic logic [1:0] win_code(
    input logic me,
    input logic peer
  );
    return {peer, me};
  endfunction

endpackage

// File: rtl/game_master_ctrl_if.sv
// Interboard link bundle between the master sequencer
// and InterboardCommunication_top.
interface game_master_ctrl_if;
  logic       inter_ready;
  logic       interboard_en;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;
  logic       transmit;
  logic       ctrl_en;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;

  modport master (
    input  inter_ready,
    input  interboard_en,
    input  interboard_msg_type,
    input  interboard_number,
    output transmit,
    output ctrl_en,
    output ctrl_msg_type,
    output ctrl_number
  );

  modport slave (
    output inter_ready,
    output interboard_en,
    output interboard_msg_type,
    output interboard_number,
    input  transmit,
    input  ctrl_en,
    input  ctrl_msg_type,
    input  ctrl_number
  );
endinterface

// File: rtl/game_master_ctrl_tx_slot.sv
// One-entry transmit holding slot: releases a queued message
// only while the link is idle and holds ctrl_* until the next send.
module master_tx_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic [2:0] type_i,
  input  logic [4:0] num_i,
  output logic       rdy_o,
  game_master_ctrl_if.master link
);

  logic       pend_q, pend_d;
  logic [2:0] ptype_q, ptype_d;
  logic [4:0] pnum_q, pnum_d;
  logic [2:0] otype_q, otype_d;
  logic [4:0] onum_q, onum_d;
  logic       fire;

  assign fire  = pend_q & link.inter_ready;
  assign rdy_o = ~pend_q | fire;

  always_comb begin
    pend_d  = pend_q;
    ptype_d = ptype_q;
    pnum_d  = pnum_q;
    otype_d = otype_q;
    onum_d  = onum_q;
    if (fire) begin
      pend_d  = 1'b0;
      otype_d = ptype_q;
      onum_d  = pnum_q;
    end
    if (req_i) begin
      pend_d  = 1'b1;
      ptype_d = type_i;
      pnum_d  = num_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      ptype_q <= '0;
      pnum_q  <= '0;
      otype_q <= '0;
      onum_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      ptype_q <= ptype_d;
      pnum_q  <= pnum_d;
      otype_q <= otype_d;
      onum_q  <= onum_d;
    end
  end

  // The sent word is visible in the fire cycle, then latched.
  assign link.transmit      = fire;
  assign link.ctrl_en       = fire;
  assign link.ctrl_msg_type = fire ? ptype_q : otype_q;
  assign link.ctrl_number   = fire ? pnum_q : onum_q;

endmodule

// File: rtl/game_master_ctrl.sv
// Master-board Bingo turn sequencer: starts the game, alternates
// turns with the slave board and declares the winner.
module game_master_ctrl
  import bingo_pkg::*;
#(
  parameter logic [25:0] TIMEOUT_CYC = 26'd50_000_000,
  parameter int          WIN_DLY     = 2
) (
  input  logic       clk,
  input  logic       rst,
  game_master_ctrl_if.master link,
  input  logic       start_game,
  output logic       start_sel,
  input  logic       sel_done,
  output logic       start_guess,
  input  logic       guess_done,
  input  logic [4:0] guess_number,
  output logic       mark_en,
  output logic [4:0] mark_number,
  input  logic       i_win,
  output logic [1:0] winner,
  output logic       abort,
  output logic [3:0] state_o
);

  state_e state_q, state_d;

  logic loc_sel_q, loc_sel_d;
  logic rem_sel_q, rem_sel_d;
  logic rep_q, rep_d;
  logic rem_line_q, rem_line_d;
  logic loc_ok_q, loc_ok_d;
  logic loc_line_q, loc_line_d;
  logic who_q, who_d;
  logic abort_q, abort_d;
  logic [1:0] winner_q, winner_d;
  logic [4:0] num_q, num_d;
  logic [25:0] tmo_q, tmo_d;
  logic [WIN_DLY-1:0] sr_q, sr_d;

  logic       tx_req, slot_rdy;
  logic [2:0] tx_type;
  logic [4:0] tx_num;
  logic       rx_sel, rx_rep, rx_guess;
  logic       timed, tmo_hit;
  logic [1:0] wcode;

  master_tx_slot u_slot (
    .clk    (clk),
    .rst    (rst),
    .req_i  (tx_req),
    .type_i (tx_type),
    .num_i  (tx_num),
    .rdy_o  (slot_rdy),
    .link   (link)
  );

  assign rx_sel = link.interboard_en &
                  (link.interboard_msg_type == MSG_SEL_DONE);
  assign rx_rep = link.interboard_en &
                  (link.interboard_msg_type == MSG_REPORT);
  assign rx_guess = link.interboard_en &
                    (link.interboard_msg_type == MSG_GUESS) &
                    (link.interboard_number <= MAX_NUM);

  assign timed = (state_q == S_SELECT) |
                 (state_q == S_WAIT_REP) |
                 (state_q == S_PEER_TURN);
  assign tmo_hit = timed &
                   (tmo_q == 26'(TIMEOUT_CYC - 26'd1));
  assign wcode = win_code(loc_line_q, rem_line_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start_game) state_d = S_SEND_START;
      S_SEND_START:
        if (slot_rdy) state_d = S_SELECT;
      S_SELECT:
        if ((loc_sel_q | sel_done) & (rem_sel_q | rx_sel))
          state_d = S_MY_TURN;
      S_MY_TURN:
        state_d = S_MY_WAIT;
      S_MY_WAIT:
        if (guess_done) state_d = S_MY_TX;
      S_MY_TX:
        if (slot_rdy) state_d = S_WAIT_REP;
      S_WAIT_REP:
        if (rep_q & loc_ok_q) state_d = S_DECIDE;
      S_DECIDE:
        if (wcode == WIN_NONE)
          state_d = who_q ? S_PEER_TURN : S_MY_TURN;
        else if (slot_rdy)
          state_d = S_GAME_OVER;
      S_PEER_TURN:
        if (rx_guess) state_d = S_WAIT_REP;
      S_GAME_OVER:
        if (start_game) state_d = S_SEND_START;
      default:
        state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end

  always_comb begin
    tx_req      = 1'b0;
    tx_type     = MSG_START;
    tx_num      = '0;
    start_sel   = 1'b0;
    start_guess = 1'b0;
    mark_en     = 1'b0;
    mark_number = '0;
    unique case (state_q)
      S_SEND_START: begin
        tx_req    = slot_rdy;
        start_sel = slot_rdy;
      end
      S_MY_TURN:
        start_guess = 1'b1;
      S_MY_TX: begin
        tx_req      = slot_rdy;
        tx_type     = MSG_GUESS;
        tx_num      = num_q;
        mark_en     = slot_rdy;
        mark_number = slot_rdy ? num_q : 5'd0;
      end
      S_PEER_TURN: begin
        mark_en     = rx_guess;
        mark_number = rx_guess ? link.interboard_number : 5'd0;
      end
      S_DECIDE: begin
        tx_req  = (wcode != WIN_NONE) & slot_rdy;
        tx_type = MSG_RESULT;
        tx_num  = {3'b000, wcode};
      end
      S_GAME_OVER: begin
        tx_req  = start_game;
        tx_type = MSG_RESTART;
      end
      default: ;
    endcase
  end

  // Turn bookkeeping, line flags and the abort timer.
  always_comb begin
    loc_sel_d  = loc_sel_q;
    rem_sel_d  = rem_sel_q;
    rep_d      = rep_q;
    rem_line_d = rem_line_q;
    loc_ok_d   = loc_ok_q;
    loc_line_d = loc_line_q;
    who_d      = who_q;
    abort_d    = abort_q;
    winner_d   = winner_q;
    num_d      = num_q;
    sr_d       = WIN_DLY'({sr_q, mark_en});
    tmo_d      = (timed & (state_d == state_q)) ?
                 tmo_q + 26'd1 : 26'd0;
    if (state_q == S_IDLE && start_game) abort_d = 1'b0;
    if (state_q == S_SEND_START) begin
      loc_sel_d = 1'b0;
      rem_sel_d = 1'b0;
    end
    if (state_q == S_SELECT) begin
      if (sel_done) loc_sel_d = 1'b1;
      if (rx_sel)   rem_sel_d = 1'b1;
    end
    if (state_q == S_MY_WAIT && guess_done) num_d = guess_number;
    if (mark_en) begin
      rep_d    = 1'b0;
      loc_ok_d = 1'b0;
      who_d    = (state_q == S_MY_TX);
    end
    if (state_q == S_WAIT_REP && rx_rep) begin
      rep_d      = 1'b1;
      rem_line_d = link.interboard_number[0];
    end
    if (sr_q[WIN_DLY-1]) begin
      loc_ok_d   = 1'b1;
      loc_line_d = i_win;
    end
    if (state_q == S_DECIDE && wcode != WIN_NONE && slot_rdy)
      winner_d = wcode;
    if (state_q == S_GAME_OVER && start_game) winner_d = WIN_NONE;
    if (tmo_hit) begin
      abort_d  = 1'b1;
      winner_d = WIN_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loc_sel_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
      rep_q      <= 1'b0;
      rem_line_q <= 1'b0;
      loc_ok_q   <= 1'b0;
      loc_line_q <= 1'b0;
      who_q      <= 1'b0;
      abort_q    <= 1'b0;
      winner_q   <= WIN_NONE;
      num_q      <= '0;
      tmo_q      <= '0;
      sr_q       <= '0;
    end else begin
      loc_sel_q  <= loc_sel_d;
      rem_sel_q  <= rem_sel_d;
      rep_q      <= rep_d;
      rem_line_q <= rem_line_d;
      loc_ok_q   <= loc_ok_d;
      loc_line_q <= loc_line_d;
      who_q      <= who_d;
      abort_q    <= abort_d;
      winner_q   <= winner_d;
      num_q      <= num_d;
      tmo_q      <= tmo_d;
      sr_q       <= sr_d;
    end
  end

  assign winner  = winner_q;
  assign abort   = abort_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_game_master_ctrl.sv
// Scoreboard bench for game_master_ctrl: stimulus pushes expected
// link words, marks and pulses; a negedge monitor pops and compares.
module tb_game_master_ctrl;
  import bingo_pkg::*;

  localparam int TMO = 300;

  typedef struct packed {
    logic [2:0] t;
    logic [4:0] n;
  } tx_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_game, start_sel, sel_done, start_guess;
  logic       guess_done, mark_en, i_win, abort;
  logic [4:0] guess_number, mark_number;
  logic [1:0] winner;
  logic [3:0] state_o;

  int   nvec  = 0;
  int   nfail = 0;
  tx_t  txq[$];
  int   mkq[$];
  int   pq[$];
  int   ncyc;

  game_master_ctrl_if lk ();

  game_master_ctrl #(
    .TIMEOUT_CYC (26'(TMO)),
    .WIN_DLY     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .link         (lk),
    .start_game   (start_game),
    .start_sel    (start_sel),
    .sel_done     (sel_done),
    .start_guess  (start_guess),
    .guess_done   (guess_done),
    .guess_number (guess_number),
    .mark_en      (mark_en),
    .mark_number  (mark_number),
    .i_win        (i_win),
    .winner       (winner),
    .abort        (abort),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: every DUT event must match the head of its queue.
  always @(negedge clk) begin
    tx_t e;
    int  m, p;
    if (!rst) begin
      if (lk.transmit) begin
        if (txq.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          e = txq.pop_front();
          chk("tx_type", int'(lk.ctrl_msg_type), int'(e.t));
          chk("tx_num", int'(lk.ctrl_number), int'(e.n));
          chk("ctrl_en", int'(lk.ctrl_en), 1);
        end
      end
      if (mark_en) begin
        if (mkq.size() == 0) chk("mark_unexpected", 1, 0);
        else begin
          m = mkq.pop_front();
          chk("mark_number", int'(mark_number), m);
        end
      end
      if (start_sel) begin
        if (pq.size() == 0) chk("sel_pulse_unexpected", 1, 0);
        else begin
          p = pq.pop_front();
          chk("pulse_start_sel", 1, p);
        end
      end
      if (start_guess) begin
        if (pq.size() == 0) chk("guess_pulse_unexpected", 1, 0);
        else begin
          p = pq.pop_front();
          chk("pulse_start_guess", 2, p);
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [2:0] t, input logic [4:0] n);
    step(1);
    lk.interboard_en       = 1'b1;
    lk.interboard_msg_type = t;
    lk.interboard_number   = n;
    step(1);
    lk.interboard_en = 1'b0;
  endtask

  task automatic wait_st(input string nm, input state_e s,
                         input int lim, output int n);
    n = 0;
    while (state_o != s && n < lim) begin
      step(1);
      n++;
    end
    chk(nm, int'(state_o), int'(s));
  endtask

  task automatic pulse_start();
    start_game = 1'b1;
    step(1);
    start_game = 1'b0;
  endtask

  task automatic do_guess(input logic [4:0] g);
    guess_number = g;
    guess_done   = 1'b1;
    step(1);
    guess_done = 1'b0;
  endtask

  task automatic both_sel();
    sel_done               = 1'b1;
    lk.interboard_en       = 1'b1;
    lk.interboard_msg_type = MSG_SEL_DONE;
    lk.interboard_number   = 5'd0;
    step(1);
    sel_done         = 1'b0;
    lk.interboard_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_game = 0; sel_done = 0; guess_done = 0;
    guess_number = 0; i_win = 0;
    lk.inter_ready = 1'b1;
    lk.interboard_en = 1'b0;
    lk.interboard_msg_type = 3'd0;
    lk.interboard_number = 5'd0;
    step(2);
    chk("rst_state", int'(state_o), int'(S_IDLE));
    chk("rst_winner", int'(winner), 0);
    chk("rst_abort", int'(abort), 0);
    chk("rst_transmit", int'(lk.transmit), 0);
    chk("rst_ctrl_type", int'(lk.ctrl_msg_type), 0);
    rst = 1'b0;
    step(1);

    // Game 1: start, staggered select, delayed GUESS tx, tie.
    txq.push_back('{MSG_START, 5'd0});
    pq.push_back(1);
    pulse_start();
    wait_st("st_select", S_SELECT, 10, ncyc);
    sel_done = 1'b1;
    step(1);
    sel_done = 1'b0;
    step(200);
    chk("still_select", int'(state_o), int'(S_SELECT));
    pq.push_back(2);
    rx(MSG_SEL_DONE, 5'd0);
    wait_st("st_my_wait", S_MY_WAIT, 10, ncyc);
    i_win = 1'b1;
    lk.inter_ready = 1'b0;
    txq.push_back('{MSG_GUESS, 5'd7});
    mkq.push_back(7);
    do_guess(5'd7);
    step(10);
    chk("guess_held", txq.size(), 1);
    chk("mark_done", mkq.size(), 0);
    lk.inter_ready = 1'b1;
    step(1);
    lk.inter_ready = 1'b0;
    step(3);
    chk("tx_sent", txq.size(), 0);
    chk("hold_type", int'(lk.ctrl_msg_type), int'(MSG_GUESS));
    chk("hold_num", int'(lk.ctrl_number), 7);
    lk.inter_ready = 1'b1;
    txq.push_back('{MSG_RESULT, 5'd3});
    rx(MSG_REPORT, 5'd1);
    wait_st("st_over1", S_GAME_OVER, 10, ncyc);
    chk("winner_tie", int'(winner), int'(WIN_TIE));

    // Game 2: restart, simultaneous select, master win.
    txq.push_back('{MSG_RESTART, 5'd0});
    txq.push_back('{MSG_START, 5'd0});
    pq.push_back(1);
    i_win = 1'b0;
    pulse_start();
    wait_st("st_select2", S_SELECT, 10, ncyc);
    chk("winner_clr", int'(winner), 0);
    pq.push_back(2);
    both_sel();
    wait_st("st_my_wait2", S_MY_WAIT, 10, ncyc);
    i_win = 1'b1;
    txq.push_back('{MSG_GUESS, 5'd3});
    mkq.push_back(3);
    do_guess(5'd3);
    txq.push_back('{MSG_RESULT, 5'd1});
    rx(MSG_REPORT, 5'd0);
    wait_st("st_over2", S_GAME_OVER, 10, ncyc);
    chk("winner_master", int'(winner), int'(WIN_MASTER));

    // Game 3: no line, peer turn, bad numbers, then timeout.
    txq.push_back('{MSG_RESTART, 5'd0});
    txq.push_back('{MSG_START, 5'd0});
    pq.push_back(1);
    i_win = 1'b0;
    pulse_start();
    wait_st("st_select3", S_SELECT, 10, ncyc);
    pq.push_back(2);
    both_sel();
    wait_st("st_my_wait3", S_MY_WAIT, 10, ncyc);
    txq.push_back('{MSG_GUESS, 5'd5});
    mkq.push_back(5);
    do_guess(5'd5);
    rx(MSG_REPORT, 5'd0);
    wait_st("st_peer", S_PEER_TURN, 10, ncyc);
    rx(MSG_GUESS, 5'd25);
    rx(MSG_START, 5'd3);
    step(2);
    chk("peer_ignore", int'(state_o), int'(S_PEER_TURN));
    mkq.push_back(12);
    rx(MSG_GUESS, 5'd12);
    wait_st("st_wait_rep_p", S_WAIT_REP, 10, ncyc);
    pq.push_back(2);
    rx(MSG_REPORT, 5'd0);
    wait_st("st_my_wait4", S_MY_WAIT, 10, ncyc);
    chk("winner_none", int'(winner), 0);
    txq.push_back('{MSG_GUESS, 5'd9});
    mkq.push_back(9);
    do_guess(5'd9);
    wait_st("st_wait_rep", S_WAIT_REP, 10, ncyc);
    rx(MSG_START, 5'd0);
    chk("rep_ignore", int'(state_o), int'(S_WAIT_REP));
    wait_st("st_tmo_idle", S_IDLE, TMO + 20, ncyc);
    chk("tmo_window", int'(ncyc >= TMO - 12 && ncyc <= TMO), 1);
    chk("abort_set", int'(abort), 1);
    chk("abort_winner", int'(winner), 0);

    // Game 4: abort clears, reset mid-WAIT_REP drops pending tx.
    txq.push_back('{MSG_START, 5'd0});
    pq.push_back(1);
    pulse_start();
    wait_st("st_select5", S_SELECT, 10, ncyc);
    chk("abort_clr", int'(abort), 0);
    pq.push_back(2);
    both_sel();
    wait_st("st_my_wait5", S_MY_WAIT, 10, ncyc);
    lk.inter_ready = 1'b0;
    mkq.push_back(4);
    do_guess(5'd4);
    step(3);
    chk("st_wait_rep5", int'(state_o), int'(S_WAIT_REP));
    rst = 1'b1;
    #1;
    chk("mrst_state", int'(state_o), int'(S_IDLE));
    chk("mrst_transmit", int'(lk.transmit), 0);
    chk("mrst_ctrl_type", int'(lk.ctrl_msg_type), 0);
    chk("mrst_ctrl_num", int'(lk.ctrl_number), 0);
    chk("mrst_pulses", int'({start_sel, start_guess, mark_en}), 0);
    chk("mrst_mark_num", int'(mark_number), 0);
    chk("mrst_winner", int'(winner), 0);
    chk("mrst_abort", int'(abort), 0);
    step(2);
    rst = 1'b0;
    lk.inter_ready = 1'b1;
    step(8);
    chk("post_rst_idle", int'(state_o), int'(S_IDLE));
    chk("txq_empty", txq.size(), 0);
    chk("mkq_empty", mkq.size(), 0);
    chk("pq_empty", pq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
